// File: rtl/mc_mem_responder.sv
// mc_mem_responder: unified instruction/data word memory for the multicycle MIPS core.
// Accepts one read or write per IDLE cycle, waits WAIT_STATES cycles, performs the array
// access, then pulses mem_ready for one cycle.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, requests with adr[1:0]!=0
// complete without touching the array, and the mem_err port flags them during DONE.
module mc_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        mem_ready
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        mem_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] WS8    = 8'(WAIT_STATES);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic                  r_we;
  logic                  r_mis;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rd_data;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_adr_mis;
  logic                  w_acc;
  logic                  w_we;
  logic                  w_mis;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_wdata;
  logic                  w_mem_we;
  logic                  w_rd_ld;

  assign w_req = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_adr_mis = |adr[1:0];
  assign mem_err   = (r_state == S_DONE) & r_mis;
  // Upper address bits are dropped so accesses wrap modulo the depth.
  logic w_unused_adr;
  assign w_unused_adr = ^adr[31:DEPTH_LOG2+2];
`else
  assign w_adr_mis = 1'b0;
  // Upper bits wrap, byte-offset bits are simply ignored.
  logic w_unused_adr;
  assign w_unused_adr = ^{adr[31:DEPTH_LOG2+2], adr[1:0]};
`endif

  // Select the access source: live inputs on the accept edge when there are no wait
  // states, otherwise the latched request on the last BUSY cycle.
  always_comb begin
    w_acc   = 1'b0;
    w_we    = r_we;
    w_mis   = r_mis;
    w_idx   = r_idx;
    w_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      if (WAIT_STATES == 0) begin
        w_acc   = w_req;
        w_we    = mem_write;
        w_mis   = w_adr_mis;
        w_idx   = adr[DEPTH_LOG2+1:2];
        w_wdata = wr_data;
      end
    end else if (r_state == S_BUSY && r_cnt == 8'd1) begin
      w_acc = 1'b1;
    end
  end

  // Gating with rst keeps an aborted access from landing in the array.
  assign w_mem_we = rst & w_acc & ~w_mis & w_we;
  assign w_rd_ld  = rst & w_acc & ~w_mis & ~w_we;

  // Request sequencing: IDLE -> (BUSY) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= mem_write;
            r_mis   <= w_adr_mis;
            r_idx   <= adr[DEPTH_LOG2+1:2];
            r_wdata <= wr_data;
            if (WAIT_STATES == 0) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= WS8;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data register: only a completed, aligned read reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_rd_data <= 32'd0;
    else if (w_rd_ld) r_rd_data <= r_mem[w_idx];
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_wdata;
  end

  assign rd_data   = r_rd_data;
  assign mem_ready = (r_state == S_DONE);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: two instances (WAIT_STATES=2 and WAIT_STATES=0) checked
// against an associative-array memory model, directed cases then random traffic.
module tb_mc_mem_responder;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdd  [2];
  logic        rd   [2];
  logic        wr   [2];
  logic        rdy  [2];
  logic        err  [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [int];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mc_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .adr(adr[0]), .wr_data(wdat[0]),
    .mem_read(rd[0]), .mem_write(wr[0]), .rd_data(rdd[0]), .mem_ready(rdy[0])
`ifdef MEM_MISALIGN_TRAP_EN
    , .mem_err(err[0])
`endif
  );

  mc_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .adr(adr[1]), .wr_data(wdat[1]),
    .mem_read(rd[1]), .mem_write(wr[1]), .rd_data(rdd[1]), .mem_ready(rdy[1])
`ifdef MEM_MISALIGN_TRAP_EN
    , .mem_err(err[1])
`endif
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance w (0: 2 wait states, 1: none). Checks mem_ready on every
  // cycle up to one past the expected strobe, and rd_data / mem_err on the strobe cycle.
  task automatic access(input int w, input bit r, input bit wrt,
                        input logic [31:0] a, input logic [31:0] d);
    int lat = (w == 0) ? 3 : 1;
    bit mis = TRAP && (a[1:0] != 2'b00);
    int key = w * 4096 + int'((a >> 2) & 32'h3FF);
    @(negedge clk);
    adr[w] = a; wdat[w] = d; rd[w] = r; wr[w] = wrt;
    @(posedge clk);
    #1 rd[w] = 1'b0; wr[w] = 1'b0;
    if (!mis) begin
      if (wrt)                     mdl[key] = d;
      else if (r && mdl.exists(key)) exp_rd[w] = mdl[key];
    end
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk($sformatf("ready[%0d] c%0d", w, c), {31'd0, rdy[w]}, {31'd0, c == lat});
      if (c == lat) begin
        chk($sformatf("rd_data[%0d]", w), rdd[w], exp_rd[w]);
`ifdef MEM_MISALIGN_TRAP_EN
        chk($sformatf("mem_err[%0d]", w), {31'd0, err[w]}, {31'd0, mis});
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = 32'd0; wdat[i] = 32'd0; rd[i] = 1'b0; wr[i] = 1'b0; exp_rd[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset rd_data[%0d]", i), rdd[i], 32'd0);
      chk($sformatf("reset ready[%0d]", i), {31'd0, rdy[i]}, 32'd0);
      chk($sformatf("reset err[%0d]", i), {31'd0, err[i]}, 32'd0);
    end
    rst = 1'b1;

    // Basic write then read with wait states.
    access(0, 0, 1, 32'h40, 32'hDEADBEEF);
    access(0, 1, 0, 32'h40, 32'h0);
    // Zero wait states.
    access(1, 0, 1, 32'h0, 32'h2002000A);
    access(1, 1, 0, 32'h0, 32'h0);
    // Read+write together acts as write; rd_data holds.
    access(0, 1, 1, 32'h8, 32'h11);
    access(0, 1, 0, 32'h8, 32'h0);
    // Address wrap.
    access(0, 0, 1, 32'h1004, 32'h5A);
    access(0, 1, 0, 32'h4, 32'h0);
    access(1, 0, 1, 32'hFFFF_F00C, 32'hA5A5_0001);
    access(1, 1, 0, 32'h0000_000C, 32'h0);

    // Reset during BUSY drops the pending write.
    access(0, 0, 1, 32'h10, 32'h1234);
    @(negedge clk);
    adr[0] = 32'h10; wdat[0] = 32'h77; wr[0] = 1'b1;
    @(posedge clk);
    #1 wr[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort ready", {31'd0, rdy[0]}, 32'd0);
    chk("abort rd_data", rdd[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    access(0, 1, 0, 32'h10, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    access(0, 0, 1, 32'h12, 32'hBAD0_BAD0);
    access(0, 1, 0, 32'h10, 32'h0);
    access(1, 1, 0, 32'h3, 32'h0);
`endif

    // Random traffic over a preloaded pool of 16 words per instance.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++)
        access(w, 0, 1, 32'(i) << 2, $urandom);
    for (int n = 0; n < 80; n++) begin
      int          w   = $urandom_range(0, 1);
      int          idx = $urandom_range(0, 15);
      int          op  = $urandom_range(0, 2);
      logic [31:0] a   = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
      access(w, op != 1, op != 0, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
